// File: rtl/seq_muldiv_unit_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings
// as decoded from IR by the control unit, and the FSM state codes.
package seq_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op_val);
        return op_val[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op_val);
        return op_val[0];
    endfunction

endpackage

// File: rtl/seq_muldiv_unit_twos_negate.sv
// Conditional two's-complement negation: o_out = i_en ? -i_in : i_in.
module twos_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_in,
    input  logic         i_en,
    output logic [W-1:0] o_out
);

    assign o_out = i_en ? (~i_in + W'(1)) : i_in;

endmodule

// File: rtl/seq_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring)
// on operand magnitudes, with a final sign-correction stage.
module seq_muldiv_unit
    import seq_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    muldiv_state_e        r_state;
    muldiv_state_e        w_state_next;
    muldiv_op_e           r_op;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_sign_lo;
    logic                 r_sign_hi;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_div_by_zero;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_accept_dz;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_part;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_fix_prod;
    logic [WIDTH-1:0]     w_fix_quo;
    logic [WIDTH-1:0]     w_fix_rem;

    twos_negate #(.W(WIDTH)) u_abs_a (
        .i_in (a),
        .i_en (op[0] & a[WIDTH-1]),
        .o_out(w_abs_a)
    );

    twos_negate #(.W(WIDTH)) u_abs_b (
        .i_in (b),
        .i_en (op[0] & b[WIDTH-1]),
        .o_out(w_abs_b)
    );

    twos_negate #(.W(2*WIDTH)) u_fix_prod (
        .i_in (r_acc),
        .i_en (r_sign_lo),
        .o_out(w_fix_prod)
    );

    twos_negate #(.W(WIDTH)) u_fix_quo (
        .i_in (r_acc[WIDTH-1:0]),
        .i_en (r_sign_lo),
        .o_out(w_fix_quo)
    );

    twos_negate #(.W(WIDTH)) u_fix_rem (
        .i_in (r_acc[2*WIDTH-1:WIDTH]),
        .i_en (r_sign_hi),
        .o_out(w_fix_rem)
    );

    assign w_accept_dz = op[1] && (b == '0);

    // Multiply: r_acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
    assign w_div_part = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_div_part >= {1'b0, r_mcand});
    assign w_div_diff = w_div_part[WIDTH-1:0] - r_mcand;
    assign w_div_next = {(w_div_ge ? w_div_diff : w_div_part[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_accept_dz ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN:  if (r_cnt == CNT_W'(1)) w_state_next = ST_FIX;
            ST_FIX:  if (r_cnt == '0) w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_op          <= OP_MULU;
            r_cnt         <= '0;
            r_mcand       <= '0;
            r_acc         <= '0;
            r_sign_lo     <= 1'b0;
            r_sign_hi     <= 1'b0;
            r_dz          <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op          <= muldiv_op_e'(op);
                        r_hi          <= '0;
                        r_lo          <= '0;
                        r_div_by_zero <= 1'b0;
                        if (w_accept_dz) begin
                            // Divide by zero spends two cycles in FIX, giving a fixed short latency.
                            r_acc     <= {a, {WIDTH{1'b1}}};
                            r_mcand   <= '0;
                            r_sign_lo <= 1'b0;
                            r_sign_hi <= 1'b0;
                            r_dz      <= 1'b1;
                            r_cnt     <= CNT_W'(1);
                        end else begin
                            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                            r_mcand   <= op[1] ? w_abs_b : w_abs_a;
                            r_sign_lo <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_sign_hi <= op[0] & (op[1] ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
                            r_dz      <= 1'b0;
                            r_cnt     <= CNT_W'(WIDTH);
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
                end
                ST_FIX: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_div_by_zero <= r_dz;
                        if (op_is_div(r_op)) begin
                            r_hi <= w_fix_rem;
                            r_lo <= w_fix_quo;
                        end else begin
                            r_hi <= w_fix_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_fix_prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign done        = (r_state == ST_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed-vector bench for seq_muldiv_unit (WIDTH=32), one line per transaction.
module tb_seq_muldiv_unit;
    import seq_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge (cycle 0 = start cycle); returns at the negedge after done.
    task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz, input int exp_lat);
        int n = 0;
        int busy_cnt = 0;
        bit seen = 0;
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check_eq({tag, "/acc_clr"}, {31'd0, div_by_zero, hi}, 64'd0);
            end
            if (done) seen = 1;
            else if (busy) busy_cnt++;
        end
        check_eq({tag, "/latency"}, 64'(n), 64'(exp_lat));
        check_eq({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check_eq({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "/hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, "/lo"}, 64'(lo), 64'(exp_lo));
        check_eq({tag, "/dz"}, 64'(div_by_zero), 64'(exp_dz));
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d [%s]",
                 op_i, a_i, b_i, hi, lo, div_by_zero, n, tag);
        @(negedge clk);
        check_eq({tag, "/done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int done1;
        int done2;
        int ndone;
        logic [31:0] lo1;
        logic [31:0] lo2;

        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check_eq("reset/outs", {29'd0, busy, done, div_by_zero, hi}, 64'd0);
        check_eq("reset/lo", 64'(lo), 64'd0);

        run_op("mul_neg3x7",   OP_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
        run_op("mulu_max_sq",  OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
        run_op("mul_m1_sq",    OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34);
        run_op("mul_min_sq",   OP_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
        run_op("mulu_carry",   OP_MULU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 34);
        run_op("mulu_zero",    OP_MULU, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, 34);
        run_op("div_neg7_2",   OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        run_op("div_7_neg2",   OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
        run_op("div_neg7_neg2",OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34);
        run_op("divu_7_2",     OP_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34);
        run_op("divu_5_9",     OP_DIVU, 32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000, 1'b0, 34);
        run_op("divu_by0",     OP_DIVU, 32'h0000002A, 32'h00000000, 32'h0000002A, 32'hFFFFFFFF, 1'b1, 3);
        run_op("dz_cleared",   OP_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34);
        run_op("div_min_m1",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
        run_op("div_by0_sgn",  OP_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 3);

        // clr in IDLE wipes held results and the flag
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("clr_idle/hi_dz", {31'd0, div_by_zero, hi}, 64'd0);
        check_eq("clr_idle/lo", 64'(lo), 64'd0);
        $display("clr in idle -> hi=%h lo=%h dz=%0d", hi, lo, div_by_zero);

        // Starts in cycles 5 (RUN) and 34 (DONE) are ignored; start held into cycle 35 is accepted.
        start = 1'b1; op = OP_MULU; a = 32'd3; b = 32'd5;
        n = 0; done1 = 0; done2 = 0; lo1 = '0; lo2 = '0;
        while (n < 120 && done2 == 0) begin
            @(negedge clk);
            n++;
            if (done && done1 == 0) begin
                done1 = n; lo1 = lo;
            end else if (done) begin
                done2 = n; lo2 = lo;
            end
            start = (n == 5) || (n == 34) || (n == 35);
            if (n == 5) begin
                op = OP_DIVU; a = 32'd100; b = 32'd7;
            end else if (n >= 34) begin
                op = OP_MULU; a = 32'd6; b = 32'd7;
            end
        end
        start = 1'b0;
        check_eq("hs/done1_cycle", 64'(done1), 64'd34);
        check_eq("hs/lo1", 64'(lo1), 64'd15);
        check_eq("hs/done2_cycle", 64'(done2), 64'd69);
        check_eq("hs/lo2", 64'(lo2), 64'd42);
        $display("handshake -> first done cycle %0d lo=%0d, second done cycle %0d lo=%0d",
                 done1, lo1, done2, lo2);
        @(negedge clk);

        // clr at cycle 10 of a running MUL aborts it with no done pulse.
        start = 1'b1; op = OP_MUL; a = 32'hFFFFFFFD; b = 32'h00000007;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check_eq("abort/busy_before", 64'(busy), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("abort/busy", 64'(busy), 64'd0);
        check_eq("abort/hi_lo", {hi, lo}, 64'd0);
        check_eq("abort/done", 64'(done), 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check_eq("abort/no_activity", 64'(ndone), 64'd0);
        $display("abort at cycle 10 -> busy=%0d hi=%h lo=%h later done/busy cycles=%0d",
                 busy, hi, lo, ndone);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
